fns_stim_sig: RTL and testbench

- Stimulus-and-signature companion for the function-port systest DUTs (the `dut` with in1/in2 -> out1..out5).
- Drives the DUT's two 8-bit inputs from an LFSR vector stream.
- Compresses the DUT's five 8-bit outputs into a 40-bit MISR signature.
- Sits at the opposite end of the DUT interface so that simulator runs can be compared by signature alone.

---
 rtl/fns_stim_sig.sv | 134 +++++++++++++
 tb/tb_fns_stim_sig.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fns_stim_sig.sv
// LFSR stimulus source and 40-bit MISR signature sink for a two-input/five-output DUT.
// One vector per cycle, done NVEC edges after start; no backpressure, start ignored while running.
module fns_stim_sig #(
   parameter logic [7:0]  SEED = 8'hA5,
   parameter int unsigned NVEC = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  out1,
   input  logic [7:0]  out2,
   input  logic [7:0]  out3,
   input  logic [7:0]  out4,
   input  logic [7:0]  out5,
   output logic [7:0]  in1,
   output logic [7:0]  in2,
   output logic        busy,
   output logic        done,
   output logic [7:0]  count,
   output logic [39:0] signature
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   // An all-zero seed would lock the LFSR, so it is promoted to 8'h01.
   localparam logic [7:0]  SEED_LD   = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [8:0]  NVEC_W    = 9'(NVEC);
   localparam logic [39:0] MISR_POLY = 40'h00_0000_0039;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
   endfunction

   function automatic logic [7:0] nib_swap(input logic [7:0] v);
      return {v[3:0], v[7:4]};
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [7:0]  in1_q, in1_d;
   logic [7:0]  in2_q, in2_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  count_q, count_d;
   logic [39:0] sig_q, sig_d;

   logic [39:0] capture;
   logic [7:0]  lfsr_nxt;
   logic        last_vec;

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      busy_d   = busy_q;
      done_d   = done_q;
      count_d  = count_q;
      sig_d    = sig_q;
      capture  = {out5, out4, out3, out2, out1};
      lfsr_nxt = lfsr_step(lfsr_q);
      last_vec = (({1'b0, count_q} + 9'd1) == NVEC_W);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               lfsr_d  = SEED_LD;
               in1_d   = SEED_LD;
               in2_d   = nib_swap(SEED_LD);
               count_d = 8'd0;
               sig_d   = 40'd0;
               if (NVEC_W == 9'd0) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
               end
            end
         end
         ST_RUN: begin
            // The vector on in1/in2 this cycle is the one whose response is captured now.
            sig_d   = {sig_q[38:0], 1'b0} ^ (sig_q[39] ? MISR_POLY : 40'd0) ^ capture;
            count_d = count_q + 8'd1;
            if (last_vec) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               lfsr_d = lfsr_nxt;
               in1_d  = lfsr_nxt;
               in2_d  = nib_swap(lfsr_nxt);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         lfsr_q  <= 8'd0;
         in1_q   <= 8'd0;
         in2_q   <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= 8'd0;
         sig_q   <= 40'd0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         count_q <= count_d;
         sig_q   <= sig_d;
      end
   end

   assign in1       = in1_q;
   assign in2       = in2_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign count     = count_q;
   assign signature = sig_q;

endmodule

// File: tb/tb_fns_stim_sig.sv
// Directed bench for fns_stim_sig: several parameterisations, hand-computed vectors and signatures.
module tb_fns_stim_sig;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // a: NVEC=1, b: NVEC=3, c: NVEC=2, d: SEED=0 NVEC=2, e: NVEC=0, f: NVEC=16
   logic        start_a, start_b, start_c, start_d, start_e, start_f;
   logic [7:0]  o_b5, o_f1;
   logic [7:0]  in1_a, in2_a, cnt_a;  logic busy_a, done_a;  logic [39:0] sig_a;
   logic [7:0]  in1_b, in2_b, cnt_b;  logic busy_b, done_b;  logic [39:0] sig_b;
   logic [7:0]  in1_c, in2_c, cnt_c;  logic busy_c, done_c;  logic [39:0] sig_c;
   logic [7:0]  in1_d, in2_d, cnt_d;  logic busy_d, done_d;  logic [39:0] sig_d;
   logic [7:0]  in1_e, in2_e, cnt_e;  logic busy_e, done_e;  logic [39:0] sig_e;
   logic [7:0]  in1_f, in2_f, cnt_f;  logic busy_f, done_f;  logic [39:0] sig_f;

   fns_stim_sig #(.SEED(8'hA5), .NVEC(1)) u_a (
      .clk(clk), .reset(reset), .start(start_a),
      .out1(8'h01), .out2(8'h02), .out3(8'h03), .out4(8'h04), .out5(8'h05),
      .in1(in1_a), .in2(in2_a), .busy(busy_a), .done(done_a), .count(cnt_a), .signature(sig_a));

   fns_stim_sig #(.SEED(8'hA5), .NVEC(3)) u_b (
      .clk(clk), .reset(reset), .start(start_b),
      .out1(8'h00), .out2(8'h00), .out3(8'h00), .out4(8'h00), .out5(o_b5),
      .in1(in1_b), .in2(in2_b), .busy(busy_b), .done(done_b), .count(cnt_b), .signature(sig_b));

   fns_stim_sig #(.SEED(8'hA5), .NVEC(2)) u_c (
      .clk(clk), .reset(reset), .start(start_c),
      .out1(8'h01), .out2(8'h00), .out3(8'h00), .out4(8'h00), .out5(8'h00),
      .in1(in1_c), .in2(in2_c), .busy(busy_c), .done(done_c), .count(cnt_c), .signature(sig_c));

   fns_stim_sig #(.SEED(8'h00), .NVEC(2)) u_d (
      .clk(clk), .reset(reset), .start(start_d),
      .out1(8'h00), .out2(8'h00), .out3(8'h00), .out4(8'h00), .out5(8'h00),
      .in1(in1_d), .in2(in2_d), .busy(busy_d), .done(done_d), .count(cnt_d), .signature(sig_d));

   fns_stim_sig #(.SEED(8'hA5), .NVEC(0)) u_e (
      .clk(clk), .reset(reset), .start(start_e),
      .out1(8'h00), .out2(8'h00), .out3(8'h00), .out4(8'h00), .out5(8'h00),
      .in1(in1_e), .in2(in2_e), .busy(busy_e), .done(done_e), .count(cnt_e), .signature(sig_e));

   fns_stim_sig #(.SEED(8'hA5), .NVEC(16)) u_f (
      .clk(clk), .reset(reset), .start(start_f),
      .out1(o_f1), .out2(8'h00), .out3(8'h00), .out4(8'h00), .out5(8'h00),
      .in1(in1_f), .in2(in2_f), .busy(busy_f), .done(done_f), .count(cnt_f), .signature(sig_f));

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      start_d = 1'b0; start_e = 1'b0; start_f = 1'b0;
      o_b5    = 8'h00;
      o_f1    = 8'h00;

      // Reset state, and start held across an edge while reset is high.
      #3;
      check("rst_in1", 40'(in1_a), 40'h00);
      check("rst_in2", 40'(in2_a), 40'h00);
      check("rst_busy", 40'(busy_a), 40'h0);
      check("rst_done", 40'(done_a), 40'h0);
      check("rst_count", 40'(cnt_a), 40'h00);
      check("rst_sig", sig_a, 40'h0);
      start_a = 1'b1;
      tick();
      check("rst_start_busy", 40'(busy_a), 40'h0);
      check("rst_start_in1", 40'(in1_a), 40'h00);
      reset   = 1'b0;
      start_a = 1'b0;
      tick();
      check("idle_busy", 40'(busy_a), 40'h0);

      // NVEC=1 with outputs 01..05.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("n1_busy", 40'(busy_a), 40'h1);
      check("n1_in1", 40'(in1_a), 40'hA5);
      check("n1_in2", 40'(in2_a), 40'h5A);
      tick();
      check("n1_done", 40'(done_a), 40'h1);
      check("n1_busy_end", 40'(busy_a), 40'h0);
      check("n1_count", 40'(cnt_a), 40'h01);
      check("n1_sig", sig_a, 40'h05_0403_0201);
      check("n1_in1_hold", 40'(in1_a), 40'hA5);
      tick();
      check("n1_done_hold", 40'(done_a), 40'h1);
      check("n1_sig_hold", sig_a, 40'h05_0403_0201);

      // NVEC=3, zero outputs: LFSR sequence.
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check("n3_in1_0", 40'(in1_b), 40'hA5);
      check("n3_in2_0", 40'(in2_b), 40'h5A);
      tick();
      check("n3_in1_1", 40'(in1_b), 40'hEA);
      check("n3_in2_1", 40'(in2_b), 40'hAE);
      check("n3_count_1", 40'(cnt_b), 40'h01);
      tick();
      check("n3_in1_2", 40'(in1_b), 40'h75);
      check("n3_in2_2", 40'(in2_b), 40'h57);
      check("n3_done_early", 40'(done_b), 40'h0);
      tick();
      check("n3_done", 40'(done_b), 40'h1);
      check("n3_count", 40'(cnt_b), 40'h03);
      check("n3_sig", sig_b, 40'h0);
      check("n3_in1_hold", 40'(in1_b), 40'h75);

      // Restart from DONE with out5=80: exercises MISR feedback.
      o_b5    = 8'h80;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      check("rs_sig_clr", sig_b, 40'h0);
      check("rs_count_clr", 40'(cnt_b), 40'h00);
      check("rs_done_clr", 40'(done_b), 40'h0);
      check("rs_in1", 40'(in1_b), 40'hA5);
      tick();
      check("fb_sig_1", sig_b, 40'h80_0000_0000);
      tick();
      check("fb_sig_2", sig_b, 40'h80_0000_0039);
      tick();
      check("fb_sig_3", sig_b, 40'h80_0000_004B);
      check("fb_done", 40'(done_b), 40'h1);

      // NVEC=2 with out1=01.
      start_c = 1'b1;
      tick();
      start_c = 1'b0;
      tick();
      check("n2_sig_1", sig_c, 40'h01);
      tick();
      check("n2_sig_2", sig_c, 40'h03);
      check("n2_count", 40'(cnt_c), 40'h02);

      // SEED=0 promoted to 01.
      start_d = 1'b1;
      tick();
      start_d = 1'b0;
      check("s0_in1_0", 40'(in1_d), 40'h01);
      check("s0_in2_0", 40'(in2_d), 40'h10);
      tick();
      check("s0_in1_1", 40'(in1_d), 40'hB8);
      check("s0_in2_1", 40'(in2_d), 40'h8B);
      tick();
      check("s0_done", 40'(done_d), 40'h1);

      // NVEC=0: straight to DONE.
      start_e = 1'b1;
      tick();
      start_e = 1'b0;
      check("n0_done", 40'(done_e), 40'h1);
      check("n0_busy", 40'(busy_e), 40'h0);
      check("n0_count", 40'(cnt_e), 40'h00);
      check("n0_sig", sig_e, 40'h0);
      tick();
      check("n0_count_hold", 40'(cnt_e), 40'h00);

      // NVEC=16: start pulsed at count=2 is ignored.
      start_f = 1'b1;
      tick();
      start_f = 1'b0;
      tick();
      tick();
      check("sr_count_2", 40'(cnt_f), 40'h02);
      start_f = 1'b1;
      tick();
      start_f = 1'b0;
      check("sr_count_3", 40'(cnt_f), 40'h03);
      check("sr_busy", 40'(busy_f), 40'h1);
      repeat (12) tick();
      check("sr_not_done", 40'(done_f), 40'h0);
      tick();
      check("sr_done", 40'(done_f), 40'h1);
      check("sr_count_16", 40'(cnt_f), 40'h10);

      // Restart, then reset mid-cycle at count=3.
      o_f1    = 8'h11;
      start_f = 1'b1;
      tick();
      start_f = 1'b0;
      repeat (3) tick();
      check("mr_count_3", 40'(cnt_f), 40'h03);
      check("mr_sig_pre", sig_f, 40'h77);
      #2;
      reset = 1'b1;
      #1;
      check("mr_in1", 40'(in1_f), 40'h00);
      check("mr_in2", 40'(in2_f), 40'h00);
      check("mr_busy", 40'(busy_f), 40'h0);
      check("mr_count", 40'(cnt_f), 40'h00);
      check("mr_sig", sig_f, 40'h0);
      check("mr_done_other", 40'(done_a), 40'h0);
      tick();
      reset = 1'b0;
      tick();
      check("mr_idle_busy", 40'(busy_f), 40'h0);
      check("mr_idle_in1", 40'(in1_f), 40'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
